// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports (m0 = CPU, m1 = loader/debug) plus the RAM side.
// slave is the arbiter's view; master is the view of the surrounding requesters and RAM.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              m0_req_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_ack_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_ack_o;

    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] data_i;
    logic [1:0]        gnt_o;
    logic              busy_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m0_rdata_o, m0_ack_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_rdata_o, m1_ack_o,
        output we_o, addr_o, data_o, gnt_o, busy_o,
        input  data_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m0_rdata_o, m0_ack_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_rdata_o, m1_ack_o,
        input  we_o, addr_o, data_o, gnt_o, busy_o,
        output data_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master single-port RAM arbiter: IDLE -> ACCESS (RAM_LAT cycles) -> DONE, round-robin grant.
// Define MEM_ARB_FIXED_PRIO_EN to make m0 win every tie instead of alternating.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(RAM_LAT - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              owner;
    logic              last_gnt;
    logic              pick;
    logic              any_req;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [1:0]        ack;

    assign any_req = bus.m0_req_i | bus.m1_req_i;

    // pick = 1 selects m1; only meaningful while any_req is high
`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick = ~bus.m0_req_i;
`else
    assign pick = bus.m1_req_i & (~bus.m0_req_i | ~last_gnt);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (cnt == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            ack       <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (any_req) begin
                    owner     <= pick;
                    last_gnt  <= pick;
                    cnt       <= '0;
                    cap_we    <= pick ? bus.m1_we_i    : bus.m0_we_i;
                    cap_addr  <= pick ? bus.m1_addr_i  : bus.m0_addr_i;
                    cap_wdata <= pick ? bus.m1_wdata_i : bus.m0_wdata_i;
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        ack <= owner ? 2'b10 : 2'b01;
                        if (!cap_we) begin
                            if (owner) rdata1 <= bus.data_i;
                            else       rdata0 <= bus.data_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write strobe is decoded from state, so an async reset removes it at once
    always_comb begin
        bus.we_o   = 1'b0;
        bus.addr_o = '0;
        bus.data_o = '0;
        bus.gnt_o  = '0;
        bus.busy_o = 1'b0;
        case (state)
            ACCESS: begin
                bus.we_o   = cap_we & (cnt == 4'd0);
                bus.addr_o = cap_addr;
                bus.data_o = cap_wdata;
                bus.gnt_o  = owner ? 2'b10 : 2'b01;
                bus.busy_o = 1'b1;
            end
            DONE: begin
                bus.addr_o = cap_addr;
                bus.data_o = cap_wdata;
                bus.gnt_o  = owner ? 2'b10 : 2'b01;
                bus.busy_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.m0_ack_o   = ack[0];
    assign bus.m1_ack_o   = ack[1];
    assign bus.m0_rdata_o = rdata0;
    assign bus.m1_rdata_o = rdata1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM_LAT=1 and RAM_LAT=3 instances driven side by side and compared
// every cycle against a timeline model (grant cycle g -> access g+1..g+LAT -> ack g+LAT+1).
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef enum int {QUIET, RAND, SAT} mode_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rst_target;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT0)) u_lat1 (.clk(clk), .reset(reset), .bus(bus_a));
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT1)) u_lat3 (.clk(clk), .reset(reset), .bus(bus_b));

    // Stimulus and observation arrays, index [dut][master]
    logic        req   [2][2];
    logic        we    [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [31:0] rdin  [2];
    logic        o_we  [2];
    logic [31:0] o_addr[2];
    logic [31:0] o_data[2];
    logic [1:0]  o_gnt [2];
    logic        o_busy[2];
    logic        o_ack [2][2];
    logic [31:0] o_rd  [2][2];

    assign bus_a.m0_req_i = req[0][0];   assign bus_a.m1_req_i = req[0][1];
    assign bus_a.m0_we_i = we[0][0];     assign bus_a.m1_we_i = we[0][1];
    assign bus_a.m0_addr_i = addr[0][0]; assign bus_a.m1_addr_i = addr[0][1];
    assign bus_a.m0_wdata_i = wdata[0][0]; assign bus_a.m1_wdata_i = wdata[0][1];
    assign bus_a.data_i = rdin[0];
    assign bus_b.m0_req_i = req[1][0];   assign bus_b.m1_req_i = req[1][1];
    assign bus_b.m0_we_i = we[1][0];     assign bus_b.m1_we_i = we[1][1];
    assign bus_b.m0_addr_i = addr[1][0]; assign bus_b.m1_addr_i = addr[1][1];
    assign bus_b.m0_wdata_i = wdata[1][0]; assign bus_b.m1_wdata_i = wdata[1][1];
    assign bus_b.data_i = rdin[1];

    assign o_we[0] = bus_a.we_o;     assign o_we[1] = bus_b.we_o;
    assign o_addr[0] = bus_a.addr_o; assign o_addr[1] = bus_b.addr_o;
    assign o_data[0] = bus_a.data_o; assign o_data[1] = bus_b.data_o;
    assign o_gnt[0] = bus_a.gnt_o;   assign o_gnt[1] = bus_b.gnt_o;
    assign o_busy[0] = bus_a.busy_o; assign o_busy[1] = bus_b.busy_o;
    assign o_ack[0][0] = bus_a.m0_ack_o; assign o_ack[0][1] = bus_a.m1_ack_o;
    assign o_ack[1][0] = bus_b.m0_ack_o; assign o_ack[1][1] = bus_b.m1_ack_o;
    assign o_rd[0][0] = bus_a.m0_rdata_o; assign o_rd[0][1] = bus_a.m1_rdata_o;
    assign o_rd[1][0] = bus_b.m0_rdata_o; assign o_rd[1][1] = bus_b.m1_rdata_o;

    // Reference model state
    int          nidle [2];
    int          start [2];
    int          owner [2];
    int          last  [2];
    logic        m_we  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdat[2];
    logic [31:0] m_rd  [2][2];
    logic [31:0] ref_mem[2][256];
    logic [31:0] ram    [2][256];
    bit          granted[2][2];
    int          left   [2][2];
    int          order  [2][$];
    bit          rec;
    mode_t       mode;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d != 0) ? LAT1 : LAT0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            nidle[d] = 0; start[d] = 0; owner[d] = 0; last[d] = 1;
            m_we[d] = 1'b0; m_addr[d] = '0; m_wdat[d] = '0;
            for (int m = 0; m < 2; m++) begin
                m_rd[d][m] = '0;
                granted[d][m] = 1'b0;
            end
        end
    endtask

    task automatic check_dut(input int d);
        int          k;
        logic [1:0]  e_gnt  = '0;
        logic        e_busy = 1'b0;
        logic        e_we   = 1'b0;
        logic [31:0] e_addr = '0;
        logic [31:0] e_data = '0;
        logic [1:0]  e_ack  = '0;
        string       p      = (d != 0) ? "lat3" : "lat1";
        if (reset && cyc < nidle[d]) begin
            k = cyc - start[d];
            e_gnt = (owner[d] != 0) ? 2'b10 : 2'b01;
            e_busy = 1'b1;
            e_addr = m_addr[d];
            e_data = m_wdat[d];
            if (k < lat_of(d)) e_we = m_we[d] && (k == 0);
            else               e_ack[owner[d]] = 1'b1;
        end
        check_eq({p, " gnt"},    o_gnt[d],  e_gnt);
        check_eq({p, " busy"},   o_busy[d], e_busy);
        check_eq({p, " we"},     o_we[d],   e_we);
        check_eq({p, " addr"},   o_addr[d], e_addr);
        check_eq({p, " data"},   o_data[d], e_data);
        check_eq({p, " ack"},    {o_ack[d][1], o_ack[d][0]}, e_ack);
        check_eq({p, " rdata0"}, o_rd[d][0], m_rd[d][0]);
        check_eq({p, " rdata1"}, o_rd[d][1], m_rd[d][1]);
    endtask

    task automatic set_req(input int d, input int m, input logic w, input logic [31:0] a, input logic [31:0] v);
        req[d][m] = 1'b1; we[d][m] = w; addr[d][m] = a; wdata[d][m] = v;
    endtask

    task automatic new_req(input int d, input int m);
        set_req(d, m, 1'($urandom_range(1)), 32'h10 + 32'($urandom_range(31)), $urandom);
    endtask

    task automatic update_reqs(input int d);
        bit done;
        for (int m = 0; m < 2; m++) begin
            done = reset && cyc < nidle[d] && cyc == start[d] + lat_of(d) && owner[d] == m;
            if (done) begin
                granted[d][m] = 1'b0;
                if (rec) order[d].push_back(m);
                if (mode == SAT) begin
                    left[d][m]--;
                    if (left[d][m] > 0) new_req(d, m); else req[d][m] = 1'b0;
                end else if (mode == RAND && $urandom_range(99) < 50) new_req(d, m);
                else req[d][m] = 1'b0;
            end else if (mode == RAND) begin
                if (!req[d][m] && !granted[d][m]) begin
                    if ($urandom_range(99) < 30) new_req(d, m);
                end else if (req[d][m] && $urandom_range(99) < (granted[d][m] ? 10 : 5)) begin
                    req[d][m] = 1'b0;
                end
            end
        end
    endtask

    task automatic drive_ram(input int d);
        int         k = cyc - start[d];
        logic [7:0] a = o_addr[d][7:0];
        if (o_we[d]) ram[d][a] = o_data[d];
        // Read data is only valid in the last access cycle; earlier cycles carry the inverse
        if (reset && cyc < nidle[d] && k < lat_of(d))
            rdin[d] = (k == lat_of(d) - 1) ? ram[d][a] : ~ram[d][a];
        else
            rdin[d] = $urandom;
    endtask

    task automatic model_step(input int d);
        int w;
        if (cyc >= nidle[d]) begin
            if (req[d][0] || req[d][1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                w = req[d][0] ? 0 : 1;
`else
                if (req[d][0] && req[d][1]) w = 1 - last[d];
                else                        w = req[d][0] ? 0 : 1;
`endif
                owner[d] = w; last[d] = w; granted[d][w] = 1'b1;
                m_we[d] = we[d][w]; m_addr[d] = addr[d][w]; m_wdat[d] = wdata[d][w];
                start[d] = cyc + 1;
                nidle[d] = cyc + lat_of(d) + 2;
            end
        end else begin
            if (cyc == start[d] && m_we[d]) ref_mem[d][m_addr[d][7:0]] = m_wdat[d];
            if (cyc == start[d] + lat_of(d) - 1 && !m_we[d])
                m_rd[d][owner[d]] = ref_mem[d][m_addr[d][7:0]];
        end
    endtask

    task automatic cycle_begin();
        @(negedge clk);
        check_dut(0); check_dut(1);
        update_reqs(0); update_reqs(1);
    endtask

    task automatic cycle_end();
        if (rst_target !== reset) begin
            reset = rst_target;
            if (!rst_target) begin
                #1;
                model_reset();
                check_dut(0); check_dut(1);
            end
        end
        drive_ram(0); drive_ram(1);
        if (reset) begin
            model_step(0); model_step(1);
        end
    endtask

    task automatic tick();
        cycle_begin();
        cycle_end();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bit idle;
        do begin
            tick();
            n++;
            idle = !(req[0][0] || req[0][1] || req[1][0] || req[1][1]) &&
                   (cyc + 1 >= nidle[0]) && (cyc + 1 >= nidle[1]);
        end while (n < 120 && !idle);
        check_eq({tag, " drained"}, idle, 1'b1);
    endtask

    task automatic start_rec();
        rec = 1'b1;
        order[0].delete(); order[1].delete();
    endtask

    int exp_m;

    initial begin
        model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                ram[d][i] = $urandom;
                ref_mem[d][i] = ram[d][i];
            end
            ram[d][8'h10] = 32'hDEADBEEF;
            ref_mem[d][8'h10] = 32'hDEADBEEF;
            rdin[d] = '0;
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0; left[d][m] = 0;
            end
        end
        rec = 1'b0;
        mode = QUIET;
        rst_target = 1'b0;
        repeat (3) tick();
        rst_target = 1'b1;
        tick();

        // Both masters request together four times each
        mode = SAT;
        start_rec();
        cycle_begin();
        for (int d = 0; d < 2; d++) begin
            left[d][0] = 4; left[d][1] = 4;
            new_req(d, 0); new_req(d, 1);
        end
        cycle_end();
        drain("contention");
        mode = QUIET;
        for (int d = 0; d < 2; d++) begin
            check_eq("grant count", order[d].size(), 8);
            for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                exp_m = (i < 4) ? 0 : 1;
`else
                exp_m = i % 2;
`endif
                check_eq("grant order", (i < order[d].size()) ? order[d][i] : 9, exp_m);
            end
        end

        // m0 read of preset location, then m1 write followed by m0 read-back
        cycle_begin(); for (int d = 0; d < 2; d++) set_req(d, 0, 1'b0, 32'h10, '0); cycle_end();
        drain("read 0x10");
        check_eq("lat1 m0 rdata 0x10", o_rd[0][0], 32'hDEADBEEF);
        check_eq("lat3 m0 rdata 0x10", o_rd[1][0], 32'hDEADBEEF);
        cycle_begin(); for (int d = 0; d < 2; d++) set_req(d, 1, 1'b1, 32'h20, 32'h12345678); cycle_end();
        drain("write 0x20");
        cycle_begin(); for (int d = 0; d < 2; d++) set_req(d, 0, 1'b0, 32'h20, '0); cycle_end();
        drain("read 0x20");
        check_eq("lat1 m0 rdata 0x20", o_rd[0][0], 32'h12345678);
        check_eq("lat3 m0 rdata 0x20", o_rd[1][0], 32'h12345678);

        // m1 withdraws req in its first access cycle; the access still completes
        start_rec();
        cycle_begin(); for (int d = 0; d < 2; d++) set_req(d, 1, 1'b0, 32'h24, '0); cycle_end();
        cycle_begin(); req[0][1] = 1'b0; req[1][1] = 1'b0; cycle_end();
        drain("m1 drop");
        for (int d = 0; d < 2; d++) begin
            check_eq("m1 drop ack count", order[d].size(), 1);
            check_eq("m1 drop ack owner", (order[d].size() > 0) ? order[d][0] : 9, 1);
        end

        // Reset in the first access cycle of a write, then the held m0 req is served again
        start_rec();
        cycle_begin(); for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 32'h30, 32'hA5A5_5A5A); cycle_end();
        cycle_begin(); rst_target = 1'b0; cycle_end();
        repeat (2) tick();
        rst_target = 1'b1;
        drain("after reset");
        for (int d = 0; d < 2; d++) begin
            check_eq("reset retry ack count", order[d].size(), 1);
            check_eq("reset retry owner", (order[d].size() > 0) ? order[d][0] : 9, 0);
        end
        rec = 1'b0;

        mode = RAND;
        repeat (3000) tick();
        mode = QUIET;
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
